// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request/ack memory responder with read wait states; optional write protect via MEM_RESP_WPROTECT_EN
module mem_responder #(
    parameter int          AW         = 8,
    parameter int          DW         = 8,
    parameter int          LATENCY    = 1,
    parameter int unsigned PROT_LIMIT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] data,
    input  logic          rden,
    input  logic          wren,
    output logic [DW-1:0] q,
    output logic          ack,
    output logic          busy,
    output logic          conflict,
    output logic          werr
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    localparam logic [3:0] LOAD = 4'(LATENCY - 1);

`ifdef MEM_RESP_WPROTECT_EN
    localparam bit WPROT = 1'b1;
`else
    localparam bit WPROT = 1'b0;
`endif

    logic [DW-1:0] mem [2**AW];

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [DW-1:0] q_q, q_d;
    logic          conflict_q, conflict_d;
    logic          werr_q, werr_d;
    logic          wr_allowed;
    logic          wr_en;

    // With protection compiled out this folds to 1, so werr stays constant 0.
    assign wr_allowed = !WPROT || (32'(addr) >= PROT_LIMIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        raddr_d    = raddr_q;
        q_d        = q_q;
        conflict_d = 1'b0;
        werr_d     = 1'b0;
        wr_en      = 1'b0;
        case (state_q)
            IDLE: begin
                if (wren) begin
                    wr_en      = wr_allowed;
                    werr_d     = !wr_allowed;
                    conflict_d = rden;
                    state_d    = ACK;
                end else if (rden) begin
                    raddr_d = addr;
                    cnt_d   = LOAD;
                    if (LATENCY > 1) begin
                        state_d = WAIT;
                    end else begin
                        // Zero wait states: the accepting edge is also the edge entering ACK.
                        q_d     = mem[addr];
                        state_d = ACK;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    q_d     = mem[raddr_q];
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            raddr_q    <= '0;
            q_q        <= '0;
            conflict_q <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            raddr_q    <= raddr_d;
            q_q        <= q_d;
            conflict_q <= conflict_d;
            werr_q     <= werr_d;
        end
    end

    // The array is deliberately outside reset so committed writes survive it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= data;
        end
    end

    assign q        = q_q;
    assign ack      = (state_q == ACK);
    assign busy     = (state_q != IDLE);
    assign conflict = conflict_q;
    assign werr     = werr_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (LATENCY=2, PROT_LIMIT=16)
module tb_mem_responder;

    logic       clk;
    logic       rst;
    logic [7:0] addr;
    logic [7:0] data;
    logic       rden;
    logic       wren;
    logic [7:0] q;
    logic       ack;
    logic       busy;
    logic       conflict;
    logic       werr;

    int checks = 0;
    int errors = 0;
    logic [7:0] old_val;

    mem_responder #(
        .AW         (8),
        .DW         (8),
        .LATENCY    (2),
        .PROT_LIMIT (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data     (data),
        .rden     (rden),
        .wren     (wren),
        .q        (q),
        .ack      (ack),
        .busy     (busy),
        .conflict (conflict),
        .werr     (werr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single write: ack and busy for exactly one cycle after the accepting edge.
    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic exp_werr);
        addr = a; data = d; wren = 1'b1; rden = 1'b0;
        step();
        wren = 1'b0;
        chk("wr_ack", ack, 1);
        chk("wr_busy", busy, 1);
        chk("wr_werr", werr, exp_werr);
        chk("wr_conflict", conflict, 0);
        step();
        chk("wr_ack_clear", ack, 0);
        chk("wr_busy_clear", busy, 0);
        chk("wr_werr_clear", werr, 0);
    endtask

    // Single read with LATENCY=2: ack and data two cycles after accept.
    task automatic do_read(input logic [7:0] a, input logic [7:0] exp_q);
        addr = a; rden = 1'b1; wren = 1'b0;
        step();
        rden = 1'b0;
        chk("rd_wait_ack", ack, 0);
        chk("rd_wait_busy", busy, 1);
        step();
        chk("rd_ack", ack, 1);
        chk("rd_q", q, exp_q);
        chk("rd_werr", werr, 0);
        step();
        chk("rd_ack_clear", ack, 0);
        chk("rd_busy_clear", busy, 0);
        chk("rd_q_hold", q, exp_q);
    endtask

    initial begin
        rst = 1'b1; addr = 8'h00; data = 8'h00; rden = 1'b0; wren = 1'b0;
        step();
        step();
        chk("rst_q", q, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_conflict", conflict, 0);
        chk("rst_werr", werr, 0);
        rst = 1'b0;
        step();
        chk("idle_busy", busy, 0);

        // Basic write then read back of the same address.
        do_write(8'h20, 8'hA5, 1'b0);
        do_read(8'h20, 8'hA5);

        // Preload top address for the held-request test.
        do_write(8'hFF, 8'h77, 1'b0);

        // Simultaneous read and write: write wins, conflict pulses with ack.
        addr = 8'h30; data = 8'h3C; rden = 1'b1; wren = 1'b1;
        step();
        rden = 1'b0; wren = 1'b0;
        chk("conf_ack", ack, 1);
        chk("conf_pulse", conflict, 1);
        chk("conf_q_unchanged", q, 8'hA5);
        step();
        chk("conf_pulse_clear", conflict, 0);
        chk("conf_ack_clear", ack, 0);
        do_read(8'h30, 8'h3C);

        // Held read request: re-accepts after ACK, acks at cycles 2 and 5.
        addr = 8'hFF; rden = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk($sformatf("held_ack_%0d", i), ack, (i == 2 || i == 5) ? 1 : 0);
            if (i == 2 || i == 5) chk($sformatf("held_q_%0d", i), q, 8'h77);
        end
        rden = 1'b0;
        step();
        chk("held_no_extra_ack", ack, 0);
        chk("held_idle", busy, 0);

        // Reset asserted during WAIT abandons the read at once.
        addr = 8'h20; rden = 1'b1;
        step();
        rden = 1'b0;
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_q", q, 0);
        chk("mid_rst_ack", ack, 0);
        step();
        rst = 1'b0;
        step();
        chk("mid_after_ack0", ack, 0);
        step();
        chk("mid_after_ack1", ack, 0);
        do_read(8'h20, 8'hA5);

`ifdef MEM_RESP_WPROTECT_EN
        do_read(8'h05, 8'hxx);
        old_val = q;
        do_write(8'h05, 8'h55, 1'b1);
        addr = 8'h05; rden = 1'b1;
        step();
        rden = 1'b0;
        step();
        chk("prot_rd_ack", ack, 1);
        checks++;
        assert (q === old_val) else begin
            errors++;
            $error("FAIL prot_rd_q: observed %0h expected %0h", q, old_val);
        end
        step();
        do_write(8'h10, 8'h66, 1'b0);
        do_read(8'h10, 8'h66);
`else
        old_val = 8'h00;
        do_write(8'h05, 8'h55, 1'b0);
        do_read(8'h05, 8'h55);
        do_write(8'h10, 8'h66, 1'b0);
        do_read(8'h10, 8'h66);
        chk("noprot_old_val_unused", {24'h0, old_val}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
